pwm_output_stage: RTL and testbench

Downstream consumer of the SPI register file. Takes the output-enable, PWM-enable and duty-cycle registers written over SPI and drives the 16 user output pins. A pin is either static high, static low, or PWM-modulated at about 3 kHz from a 10 MHz clock. Duty-cycle and PWM-enable changes are double-buffered and applied only at a period boundary, so outputs never glitch.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_output_stage_if.sv | 27 ++
 rtl/pwm_timebase.sv | 34 +++
 rtl/pwm_output_stage.sv | 64 ++++++
 tb/tb_pwm_output_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, types and the duty compare for the PWM output stage.
package pwm_pkg;

    localparam int PWM_CNT_W       = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int DEFAULT_CLK_DIV = 13;
    localparam int NUM_OUT         = 16;

    typedef logic [NUM_OUT-1:0] pin_mask_t;

    // Full-scale duty is forced high so there is no 1/256 dropout at the top count.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Register-side inputs from the SPI register file and the pin-side outputs.
interface pwm_output_stage_if;
    import pwm_pkg::*;

    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    pin_mask_t  uo_pwm;
    logic       period_start;

    // Plain level interface: register values are held stable by the writer,
    // outputs are registered by the stage; there is no valid/ready handshake.
    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  uo_pwm, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output uo_pwm, period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the last clock of each counter step and period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 tick,
    output logic                 wrap
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

    logic [PS_W-1:0] prescaler;

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (pwm_cnt == {PWM_CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives 16 pins static or PWM; duty and PWM-mode are shadowed and swapped at period boundaries.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    pwm_output_stage_if.slave  regs
);

    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic                 tick;
    logic                 wrap;
    logic                 shadow_load;

    logic [PWM_CNT_W-1:0] duty_sh;
    pin_mask_t            en_pwm_sh;
    pin_mask_t            en_out;
    pin_mask_t            en_pwm_live;
    pin_mask_t            pin_next;
    pin_mask_t            uo_q;
    logic                 period_start_q;
    logic                 pwm_high;

    pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt),
        .tick    (tick),
        .wrap    (wrap)
    );

    assign en_out      = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
    assign en_pwm_live = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};

    // wrap only ever asserts on a tick; gating keeps the load tied to a counter step.
    assign shadow_load = tick && wrap;

    always_comb begin
        pwm_high = pwm_level(pwm_cnt, duty_sh);
        pin_next = en_out & (~en_pwm_sh | {NUM_OUT{pwm_high}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh        <= '0;
            en_pwm_sh      <= '0;
            uo_q           <= '0;
            period_start_q <= 1'b0;
        end else begin
            uo_q           <= pin_next;
            period_start_q <= shadow_load;
            if (shadow_load) begin
                duty_sh   <= regs.pwm_duty_cycle;
                en_pwm_sh <= en_pwm_live;
            end
        end
    end

    assign regs.uo_pwm       = uo_q;
    assign regs.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage: reset, static pins, PWM duty shapes, shadow timing.
module tb_pwm_output_stage;
    import pwm_pkg::*;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    pwm_output_stage_if bus ();

    pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .regs (bus)
    );

    // Clock / reset
    always #50 clk = ~clk;

    initial begin
        #(100 * 90000);
        $display("FAIL watchdog: simulation time limit reached, failed=%0d", tests_failed);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic set_regs(input logic [15:0] en_out, input logic [15:0] en_pwm,
                            input logic [7:0] duty);
        bus.en_reg_out_7_0  = en_out[7:0];
        bus.en_reg_out_15_8 = en_out[15:8];
        bus.en_reg_pwm_7_0  = en_pwm[7:0];
        bus.en_reg_pwm_15_8 = en_pwm[15:8];
        bus.pwm_duty_cycle  = duty;
    endtask

    // Advances at least one negedge and stops on the first period_start; bounded.
    task automatic wait_ps(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.period_start !== 1'b1 && cycles < PERIOD + 16);
    endtask

    // Starts on a negedge showing period_start; samples pin 1 over one full period.
    // Sample k reflects counter state k-1, so it is high for k <= 13*duty.
    task automatic measure_period(input int write_at, input logic [7:0] write_val,
                                  output int high, output int first_low,
                                  output int rises, output int stray,
                                  output logic ps_end);
        logic prev;
        high = 0; first_low = 0; rises = 0; stray = 0;
        prev = 1'b1;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (bus.uo_pwm[1] === 1'b1) begin
                high++;
                if (prev == 1'b0) rises++;
                prev = 1'b1;
            end else begin
                if (first_low == 0) first_low = k;
                prev = 1'b0;
            end
            if ((bus.uo_pwm & 16'hFFFD) !== 16'h0000) stray++;
            if (k < PERIOD && bus.period_start !== 1'b0) stray++;
            if (k == write_at) bus.pwm_duty_cycle = write_val;
        end
        ps_end = bus.period_start;
    endtask

    // Scenarios
    task automatic test_reset();
        int cycles;
        rst = 1'b1;
        set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_uo: got %h expected 0000", bus.uo_pwm);
        end
        tests_run++;
        if (bus.period_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ps: got %b expected 0", bus.period_start);
        end
        rst = 1'b0;
        set_regs(16'h0000, 16'h0000, 8'h00);
        wait_ps(cycles);
        tests_run++;
        if (cycles !== PERIOD) begin
            tests_failed++;
            $display("FAIL reset_first_ps: got %0d cycles expected %0d", cycles, PERIOD);
        end
    endtask

    task automatic test_static();
        int bad;
        set_regs(16'h0001, 16'h0000, 8'h00);
        @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h0001) begin
            tests_failed++;
            $display("FAIL static_on: got %h expected 0001", bus.uo_pwm);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.uo_pwm !== 16'h0001) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL static_hold: got %0d bad samples expected 0", bad);
        end
        set_regs(16'h8001, 16'h0000, 8'h00);
        @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h8001) begin
            tests_failed++;
            $display("FAIL static_upper: got %h expected 8001", bus.uo_pwm);
        end
        set_regs(16'h0000, 16'h0000, 8'h00);
        @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h0000) begin
            tests_failed++;
            $display("FAIL static_off: got %h expected 0000", bus.uo_pwm);
        end
    endtask

    task automatic test_duty(input string name, input logic [7:0] duty, input int exp_high,
                             input int exp_first_low);
        int cycles, high, first_low, rises, stray;
        logic ps_end;
        set_regs(16'h0002, 16'h0002, duty);
        wait_ps(cycles);
        tests_run++;
        if (cycles > PERIOD) begin
            tests_failed++;
            $display("FAIL %s_wait: got %0d cycles expected <= %0d", name, cycles, PERIOD);
        end
        for (int p = 0; p < 2; p++) begin
            measure_period(-1, 8'h00, high, first_low, rises, stray, ps_end);
            tests_run++;
            if (high != exp_high || first_low != exp_first_low || rises != 0) begin
                tests_failed++;
                $display("FAIL %s_shape p%0d: got high=%0d first_low=%0d rises=%0d expected high=%0d first_low=%0d rises=0",
                         name, p, high, first_low, rises, exp_high, exp_first_low);
            end
            tests_run++;
            if (stray != 0 || ps_end !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_frame p%0d: got stray=%0d ps_end=%b expected 0 and 1",
                         name, p, stray, ps_end);
            end
        end
    endtask

    task automatic test_mid_update();
        int cycles, high, first_low, rises, stray;
        logic ps_end;
        set_regs(16'h0002, 16'h0002, 8'h40);
        wait_ps(cycles);
        measure_period(16 * CLK_DIV, 8'hC0, high, first_low, rises, stray, ps_end);
        tests_run++;
        if (high != 832 || first_low != 833 || stray != 0 || ps_end !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_current: got high=%0d first_low=%0d stray=%0d ps_end=%b expected 832 833 0 1",
                     high, first_low, stray, ps_end);
        end
        measure_period(-1, 8'h00, high, first_low, rises, stray, ps_end);
        tests_run++;
        if (high != 2496 || first_low != 2497 || rises != 0 || ps_end !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_next: got high=%0d first_low=%0d rises=%0d ps_end=%b expected 2496 2497 0 1",
                     high, first_low, rises, ps_end);
        end
    endtask

    task automatic test_reset_mid();
        int cycles, high, first_low, rises, stray;
        logic ps_end;
        set_regs(16'h0002, 16'h0002, 8'h80);
        wait_ps(cycles);
        repeat (16'h70 * CLK_DIV) @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h0002) begin
            tests_failed++;
            $display("FAIL rstmid_high_phase: got %h expected 0002", bus.uo_pwm);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.uo_pwm !== 16'h0000 || bus.period_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_clear: got uo=%h ps=%b expected 0000 0",
                     bus.uo_pwm, bus.period_start);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ps(cycles);
        tests_run++;
        if (cycles !== PERIOD) begin
            tests_failed++;
            $display("FAIL rstmid_restart: got %0d cycles expected %0d", cycles, PERIOD);
        end
        measure_period(-1, 8'h00, high, first_low, rises, stray, ps_end);
        tests_run++;
        if (high != 1664 || first_low != 1665 || ps_end !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_resume: got high=%0d first_low=%0d ps_end=%b expected 1664 1665 1",
                     high, first_low, ps_end);
        end
    endtask

    // Sequence and final report
    initial begin
        set_regs(16'h0000, 16'h0000, 8'h00);
        test_reset();
        test_static();
        test_duty("pwm50", 8'h80, 1664, 1665);
        test_duty("duty00", 8'h00, 0, 1);
        test_duty("dutyff", 8'hFF, PERIOD, 0);
        test_mid_update();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
